tcam_route_engine: RTL and testbench
====================================

// Module: tcam_route_engine
// PURPOSE
// Parametrised, banked TCAM routing table for the spike router: maps an incoming PacketID
// to every matching (DstID, Weight) entry. Replaces the single-bank, single-hit lookup with
// multi-bank compare, a popcount and a fire sequencer that streams all hits over valid/ready.
// Sits between the packet decoder (key source) and the synapse/weight accumulator (sink).
// PARAMETERS
// KEY_W      8   search key width (PacketID + axon/synapse fields)
// DST_W      4   destination-ID payload width
// WEIGHT_W   4   weight payload width
// WORDS      16  total entries; WORDS % NUM_BANKS == 0 (elaboration error otherwise)
// NUM_BANKS  2   banks; bank b holds addresses [b*WORDS/NUM_BANKS, (b+1)*WORDS/NUM_BANKS)
// ADDR_W     $clog2(WORDS)  derived, not overridden
// PORTS
// clk          in   1          clock, all logic rising-edge
// rst          in   1          synchronous, active-high reset
// mode_in      in   3          tcam_pkg::mode_e: I/W/R/F/C/RST/FLUSH
// req_valid    in   1          command valid; accepted when req_valid & req_ready
// req_ready    out  1          1 in IDLE only
// key_in       in   KEY_W      write data (W) / search key (C,F)
// mskb_in      in   KEY_W      global search mask, 1 = compare bit
// payload_in   in   DST_W+WEIGHT_W  {dst,weight} written with data row (W, dcs_in=1)
// addr_in      in   ADDR_W     entry address (W,R)
// dcs_in       in   1          1 = data row, 0 = care row (W,R)
// vbe_in/vbi_in in  1/1        valid-bit write enable / value (W)
// bank_en_in   in   NUM_BANKS  banks participating in C/F
// rd_data_o    out  KEY_W      R: data or care row per dcs_in; rd_vb_o out 1: valid bit
// rd_valid_o   out  1          R result strobe
// hit_o, hit_addr_o(ADDR_W), hit_cnt_o($clog2(WORDS+1))  C result, strobed by cmp_done_o
// out_valid, out_ready         F stream handshake
// out_dst(DST_W), out_weight(WEIGHT_W), out_addr(ADDR_W), out_last(1)  F stream beat
// fire_done_o  out  1          1-cycle pulse when F completes (incl. zero hits)
// BEHAVIOUR
// - Reset: all valid bits 0, FSM IDLE; all outputs 0 except req_ready=1. Data/care/payload
//   arrays are not reset. rst mid-scan aborts immediately: out_valid 0 next cycle, no done pulse.
// - Match(i) = vb[i] & bank_en_in[bank(i)] & ~|((data[i]^key_in) & care[i] & mskb_in).
// - W: in accepted cycle, dcs_in=1 writes data+payload, dcs_in=0 writes care; if vbe_in, vb=vbi_in.
// - R: rd_valid_o, rd_data_o, rd_vb_o valid exactly 1 cycle after accept (latency 1).
// - C: match vector registered; cmp_done_o 1 cycle after accept with hit_o=|vec,
//   hit_addr_o=lowest set index (0 if none), hit_cnt_o=popcount.
// - FLUSH: all valid bits cleared at accept edge; RST mode behaves as rst for the table.
// - I / unknown mode codes: no-op, accepted.
// - FSM IDLE -> SCAN on F accept (vector latched; later table writes do not affect it).
//   SCAN: out_* presents lowest set bit; on out_valid&out_ready that bit clears.
//   out_last=1 when exactly one bit remains. After last handshake -> IDLE, fire_done_o pulses.
//   Zero hits: stay IDLE path, fire_done_o pulses 1 cycle after accept, out_valid never rises.
//   out_* stable while out_valid & ~out_ready (AXI-style, no retraction).
// - Throughput: one beat/cycle with out_ready held high; req_ready=0 throughout SCAN.
// STRUCTURE
// - tcam_pkg: mode_e (I=000,W=001,R=010,F=011,C=100,RST=101,FLUSH=110), fsm_e {IDLE,SCAN}.
// - Sub-module tcam_prio_enc #(N): lowest-set index, one-hot, any, exactly_one; used for
//   C and SCAN. Popcount and match array stay in the top.
// TESTING
// - rst; W addr 1 data 0x5A care 0xFF vb=1; R addr1 dcs=1 -> rd_data_o=0x5A, rd_vb_o=1 at +1 cyc.
// - Entries 3,7,12 key 0x30 care 0xF0; C key 0x3F mskb 0xFF -> hit=1, addr=3, cnt=3.
// - Same table, F key 0x35, out_ready=1 -> beats addr 3,7,12, out_last on 12, fire_done next.
// - F with out_ready toggled 1010 -> no beat lost/duplicated, out_* stable while stalled.
// - bank_en=2'b01 with hits 3,12 -> only addr 3; FLUSH then C -> hit=0, cnt=0, F -> done only.
// - rst asserted during 2nd beat -> out_valid 0 next cycle, req_ready 1, R any addr -> vb=0.

Source files
------------

// File: rtl/tcam_route_engine_pkg.sv
// tcam_route_engine_pkg: command codes and sequencer states shared by the TCAM route engine
package tcam_route_engine_pkg;
  typedef enum logic [2:0] {
    MODE_I     = 3'b000,
    MODE_W     = 3'b001,
    MODE_R     = 3'b010,
    MODE_F     = 3'b011,
    MODE_C     = 3'b100,
    MODE_RST   = 3'b101,
    MODE_FLUSH = 3'b110
  } mode_e;
  typedef enum logic {IDLE, SCAN} fsm_e;
endpackage

// File: rtl/tcam_route_engine_prio_enc.sv
// tcam_prio_enc: lowest-set-bit encoder with one-hot, any and exactly-one flags
module tcam_prio_enc #(
  parameter int N = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          any,
  output logic          exactly_one
);
  assign onehot = vec & (~vec + N'(1));
  assign any = |vec;
  assign exactly_one = any & ~|(vec & (vec - N'(1)));
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = vec[i] ? IW'(i) : idx;
  end
endmodule

// File: rtl/tcam_route_engine.sv
// tcam_route_engine: banked TCAM routing table with compare, popcount and a hit-streaming fire sequencer
module tcam_route_engine
  import tcam_route_engine_pkg::*;
#(
  parameter int KEY_W     = 8,
  parameter int DST_W     = 4,
  parameter int WEIGHT_W  = 4,
  parameter int WORDS     = 16,
  parameter int NUM_BANKS = 2,
  localparam int ADDR_W   = $clog2(WORDS),
  localparam int CNT_W    = $clog2(WORDS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                mode_in,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [KEY_W-1:0]          key_in,
  input  logic [KEY_W-1:0]          mskb_in,
  input  logic [DST_W+WEIGHT_W-1:0] payload_in,
  input  logic [ADDR_W-1:0]         addr_in,
  input  logic                      dcs_in,
  input  logic                      vbe_in,
  input  logic                      vbi_in,
  input  logic [NUM_BANKS-1:0]      bank_en_in,
  output logic [KEY_W-1:0]          rd_data_o,
  output logic                      rd_vb_o,
  output logic                      rd_valid_o,
  output logic                      hit_o,
  output logic [ADDR_W-1:0]         hit_addr_o,
  output logic [CNT_W-1:0]          hit_cnt_o,
  output logic                      cmp_done_o,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DST_W-1:0]          out_dst,
  output logic [WEIGHT_W-1:0]       out_weight,
  output logic [ADDR_W-1:0]         out_addr,
  output logic                      out_last,
  output logic                      fire_done_o
);
  localparam int PL_W = DST_W + WEIGHT_W;
  localparam int BANK_SZ = WORDS / NUM_BANKS;
  if (WORDS % NUM_BANKS != 0) begin : g_bank_check
    $error("tcam_route_engine: WORDS must be a multiple of NUM_BANKS");
  end
  logic [KEY_W-1:0] data_q [WORDS];
  logic [KEY_W-1:0] care_q [WORDS];
  logic [PL_W-1:0] pl_q [WORDS];
  logic [WORDS-1:0] vb_q, match, svec_q, svec_d, enc_onehot;
  logic [ADDR_W-1:0] enc_idx;
  logic [CNT_W-1:0] pop;
  logic [PL_W-1:0] pl_sel;
  logic enc_any, enc_one, accept, beat, fire_done_d;
  fsm_e state_q, state_d;
  mode_e mode;
  assign mode = mode_e'(mode_in);
  assign req_ready = state_q == IDLE;
  assign accept = req_valid & req_ready;
  assign out_valid = state_q == SCAN;
  assign beat = out_valid & out_ready;
  always_comb begin
    match = '0;
    pop = '0;
    for (int i = 0; i < WORDS; i++) begin
      match[i] = vb_q[i] & bank_en_in[i / BANK_SZ] & ~|((data_q[i] ^ key_in) & care_q[i] & mskb_in);
      pop = pop + CNT_W'(match[i]);
    end
  end
  // One encoder serves both paths: live match vector while idle, latched hit vector while scanning.
  tcam_prio_enc #(.N(WORDS)) u_enc (
    .vec         (out_valid ? svec_q : match),
    .idx         (enc_idx),
    .onehot      (enc_onehot),
    .any         (enc_any),
    .exactly_one (enc_one)
  );
  always_ff @(posedge clk) begin
    if (accept && mode == MODE_W) begin
      if (dcs_in) begin
        data_q[addr_in] <= key_in;
        pl_q[addr_in] <= payload_in;
      end else care_q[addr_in] <= key_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || (accept && (mode == MODE_FLUSH || mode == MODE_RST))) vb_q <= '0;
    else if (accept && mode == MODE_W && vbe_in) vb_q[addr_in] <= vbi_in;
  end
  always_comb begin
    state_d = state_q;
    svec_d = svec_q;
    fire_done_d = 1'b0;
    if (accept && mode == MODE_F) begin
      svec_d = match;
      state_d = enc_any ? SCAN : IDLE;
      fire_done_d = ~enc_any;
    end else if (beat) begin
      svec_d = svec_q & ~enc_onehot;
      state_d = enc_one ? IDLE : SCAN;
      fire_done_d = enc_one;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      svec_q <= '0;
      fire_done_o <= 1'b0;
      rd_valid_o <= 1'b0;
      rd_data_o <= '0;
      rd_vb_o <= 1'b0;
      cmp_done_o <= 1'b0;
      hit_o <= 1'b0;
      hit_addr_o <= '0;
      hit_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      svec_q <= svec_d;
      fire_done_o <= fire_done_d;
      rd_valid_o <= accept && mode == MODE_R;
      cmp_done_o <= accept && mode == MODE_C;
      if (accept && mode == MODE_R) begin
        rd_data_o <= dcs_in ? data_q[addr_in] : care_q[addr_in];
        rd_vb_o <= vb_q[addr_in];
      end
      if (accept && mode == MODE_C) begin
        hit_o <= enc_any;
        hit_addr_o <= enc_idx;
        hit_cnt_o <= pop;
      end
    end
  end
  assign pl_sel = pl_q[enc_idx];
  assign out_addr = out_valid ? enc_idx : '0;
  assign out_dst = out_valid ? pl_sel[PL_W-1:WEIGHT_W] : '0;
  assign out_weight = out_valid ? pl_sel[WEIGHT_W-1:0] : '0;
  assign out_last = out_valid & enc_one;
endmodule

// File: tb/tb_tcam_route_engine.sv
// tb_tcam_route_engine: random and directed stimulus checked against a queue-based table model
module tb_tcam_route_engine;
  logic clk = 0;
  logic rst = 1;
  logic [2:0] mode_in = '0;
  logic req_valid = 0;
  logic req_ready;
  logic [7:0] key_in = '0, mskb_in = '0, payload_in = '0;
  logic [3:0] addr_in = '0;
  logic dcs_in = 0, vbe_in = 0, vbi_in = 0;
  logic [1:0] bank_en_in = 2'b11;
  logic [7:0] rd_data_o;
  logic rd_vb_o, rd_valid_o, hit_o, cmp_done_o, out_valid, out_last, fire_done_o;
  logic out_ready = 0;
  logic [3:0] hit_addr_o, out_dst, out_weight, out_addr;
  logic [4:0] hit_cnt_o;

  tcam_route_engine dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .req_valid(req_valid), .req_ready(req_ready),
    .key_in(key_in), .mskb_in(mskb_in), .payload_in(payload_in), .addr_in(addr_in),
    .dcs_in(dcs_in), .vbe_in(vbe_in), .vbi_in(vbi_in), .bank_en_in(bank_en_in),
    .rd_data_o(rd_data_o), .rd_vb_o(rd_vb_o), .rd_valid_o(rd_valid_o),
    .hit_o(hit_o), .hit_addr_o(hit_addr_o), .hit_cnt_o(hit_cnt_o), .cmp_done_o(cmp_done_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_dst(out_dst), .out_weight(out_weight),
    .out_addr(out_addr), .out_last(out_last), .fire_done_o(fire_done_o)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  bit mon_on = 0;
  logic [7:0] m_data [16];
  logic [7:0] m_care [16];
  logic [7:0] m_pl [16];
  bit m_vb [16];
  int q[$];
  int hits[$];
  bit acc, hs;
  bit e_rd, e_rd_vb, e_cmp, e_hit, e_fire;
  logic [7:0] e_rd_data;
  int e_haddr, e_hcnt;
  int beat_addr[$];
  int beat_last[$];
  int fire_gap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic fail_now(input string nm);
    total++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  // Model: command about to be accepted (or beat about to be taken) at the next rising edge.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("req_ready", req_ready, q.size() == 0);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_addr", out_addr, q[0]);
        chk("out_dst", out_dst, m_pl[q[0]] >> 4);
        chk("out_weight", out_weight, m_pl[q[0]] & 8'h0F);
        chk("out_last", out_last, q.size() == 1);
      end
      chk("rd_valid", rd_valid_o, e_rd);
      if (e_rd) begin
        chk("rd_data", rd_data_o, e_rd_data);
        chk("rd_vb", rd_vb_o, e_rd_vb);
      end
      chk("cmp_done", cmp_done_o, e_cmp);
      if (e_cmp) begin
        chk("hit", hit_o, e_hit);
        chk("hit_addr", hit_addr_o, e_haddr);
        chk("hit_cnt", hit_cnt_o, e_hcnt);
      end
      chk("fire_done", fire_done_o, e_fire);
    end
    acc = req_valid && q.size() == 0;
    hs = out_ready && q.size() != 0;
    e_rd = 0;
    e_cmp = 0;
    e_fire = 0;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_vb[i] = 0;
      q.delete();
    end else if (hs) begin
      void'(q.pop_front());
      e_fire = q.size() == 0;
    end else if (acc) begin
      hits.delete();
      for (int i = 0; i < 16; i++)
        if (m_vb[i] && bank_en_in[i / 8] && ((m_data[i] ^ key_in) & m_care[i] & mskb_in) == 0)
          hits.push_back(i);
      case (mode_in)
        3'd1: begin
          if (dcs_in) begin
            m_data[addr_in] = key_in;
            m_pl[addr_in] = payload_in;
          end else m_care[addr_in] = key_in;
          if (vbe_in) m_vb[addr_in] = vbi_in;
        end
        3'd2: begin
          e_rd = 1;
          e_rd_data = dcs_in ? m_data[addr_in] : m_care[addr_in];
          e_rd_vb = m_vb[addr_in];
        end
        3'd3: begin
          q = hits;
          e_fire = hits.size() == 0;
        end
        3'd4: begin
          e_cmp = 1;
          e_hit = hits.size() != 0;
          e_haddr = hits.size() != 0 ? hits[0] : 0;
          e_hcnt = hits.size();
        end
        3'd5, 3'd6: for (int i = 0; i < 16; i++) m_vb[i] = 0;
        default: ;
      endcase
    end
  end

  task automatic issue(input logic [2:0] m, input logic [7:0] k, input logic [7:0] mk,
                       input logic [7:0] pl, input logic [3:0] a, input logic d,
                       input logic ve, input logic vi, input logic [1:0] be);
    int n = 0;
    mode_in = m; key_in = k; mskb_in = mk; payload_in = pl; addr_in = a;
    dcs_in = d; vbe_in = ve; vbi_in = vi; bank_en_in = be; req_valid = 1;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) fail_now("accept_wait");
    @(posedge clk);
    #1 req_valid = 0;
  endtask

  task automatic wr(input logic [3:0] a, input logic d, input logic [7:0] v,
                    input logic [7:0] pl, input logic ve, input logic vi);
    issue(3'd1, v, 8'hFF, pl, a, d, ve, vi, 2'b11);
  endtask

  // pat 0: ready held high, 1: ready 1,0,1,0..., 2: random ready
  task automatic drain(input int pat);
    int last_c = -1;
    bit done = 0;
    beat_addr.delete();
    beat_last.delete();
    fire_gap = -1;
    for (int c = 0; c < 200 && !done; c++) begin
      out_ready = pat == 0 ? 1'b1 : pat == 1 ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (out_valid && out_ready) begin
        beat_addr.push_back(out_addr);
        beat_last.push_back(out_last);
        last_c = c;
      end
      if (fire_done_o) begin
        done = 1;
        fire_gap = c - last_c;
      end
      @(posedge clk);
      #1;
    end
    if (!done) fail_now("fire_wait");
  endtask

  task automatic at_neg;
    @(negedge clk);
  endtask

  task automatic to_pos;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    logic [7:0] rk;
    repeat (3) @(posedge clk);
    at_neg();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_hit_cnt", hit_cnt_o, 0);
    chk("rst_fire", fire_done_o, 0);
    chk("rst_cmp_done", cmp_done_o, 0);
    mon_on = 1;
    to_pos();
    rst = 0;
    for (int i = 0; i < 16; i++) begin
      wr(i[3:0], 1, 8'($urandom), 8'($urandom), 1, 0);
      wr(i[3:0], 0, 8'($urandom), 8'h00, 0, 0);
    end
    wr(4'd1, 1, 8'h5A, 8'hA5, 0, 0);
    wr(4'd1, 0, 8'hFF, 8'h00, 1, 1);
    issue(3'd2, 8'h00, 8'h00, 8'h00, 4'd1, 1, 0, 0, 2'b11);
    at_neg();
    chk("lit_rd_valid", rd_valid_o, 1);
    chk("lit_rd_data", rd_data_o, 8'h5A);
    chk("lit_rd_vb", rd_vb_o, 1);
    to_pos();
    issue(3'd6, 8'h00, 8'h00, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    wr(4'd3, 1, 8'h30, 8'h13, 1, 1);
    wr(4'd3, 0, 8'hF0, 8'h00, 0, 0);
    wr(4'd7, 1, 8'h30, 8'h27, 1, 1);
    wr(4'd7, 0, 8'hF0, 8'h00, 0, 0);
    wr(4'd12, 1, 8'h30, 8'h9C, 1, 1);
    wr(4'd12, 0, 8'hF0, 8'h00, 0, 0);
    issue(3'd4, 8'h3F, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    at_neg();
    chk("lit_c_done", cmp_done_o, 1);
    chk("lit_c_hit", hit_o, 1);
    chk("lit_c_addr", hit_addr_o, 3);
    chk("lit_c_cnt", hit_cnt_o, 3);
    to_pos();
    issue(3'd3, 8'h35, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    drain(0);
    chk("lit_f_beats", beat_addr.size(), 3);
    if (beat_addr.size() == 3) begin
      chk("lit_f_b0", beat_addr[0], 3);
      chk("lit_f_b1", beat_addr[1], 7);
      chk("lit_f_b2", beat_addr[2], 12);
      chk("lit_f_last1", beat_last[1], 0);
      chk("lit_f_last2", beat_last[2], 1);
    end
    chk("lit_f_fire_gap", fire_gap, 1);
    issue(3'd3, 8'h35, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    drain(1);
    chk("lit_tog_beats", beat_addr.size(), 3);
    if (beat_addr.size() == 3) chk("lit_tog_b2", beat_addr[2], 12);
    wr(4'd7, 1, 8'h30, 8'h27, 1, 0);
    issue(3'd4, 8'h3F, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b01);
    at_neg();
    chk("lit_b01_addr", hit_addr_o, 3);
    chk("lit_b01_cnt", hit_cnt_o, 1);
    to_pos();
    issue(3'd4, 8'h3F, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b10);
    at_neg();
    chk("lit_b10_addr", hit_addr_o, 12);
    chk("lit_b10_cnt", hit_cnt_o, 1);
    to_pos();
    issue(3'd6, 8'h00, 8'h00, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    issue(3'd4, 8'h3F, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    at_neg();
    chk("lit_fl_hit", hit_o, 0);
    chk("lit_fl_cnt", hit_cnt_o, 0);
    to_pos();
    issue(3'd3, 8'h3F, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    drain(0);
    chk("lit_fl_beats", beat_addr.size(), 0);
    chk("lit_fl_fire_gap", fire_gap, 1);
    wr(4'd3, 1, 8'h30, 8'h13, 1, 1);
    wr(4'd7, 1, 8'h30, 8'h27, 1, 1);
    wr(4'd12, 1, 8'h30, 8'h9C, 1, 1);
    out_ready = 1;
    issue(3'd3, 8'h35, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    to_pos();
    rst = 1;
    to_pos();
    rst = 0;
    at_neg();
    chk("lit_rst_out_valid", out_valid, 0);
    chk("lit_rst_req_ready", req_ready, 1);
    chk("lit_rst_fire", fire_done_o, 0);
    to_pos();
    issue(3'd2, 8'h00, 8'h00, 8'h00, 4'd7, 1, 0, 0, 2'b11);
    at_neg();
    chk("lit_rst_vb", rd_vb_o, 0);
    to_pos();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      rk = 8'($urandom) & 8'h33;
      if (r < 7)
        issue(3'd1, rk, 8'hFF, 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 2'b11);
      else if (r < 10)
        issue(3'd2, 8'h00, 8'h00, 8'h00, 4'($urandom), 1'($urandom), 0, 0, 2'b11);
      else if (r < 13)
        issue(3'd4, rk, 8'($urandom) | 8'hCC, 8'h00, 4'd0, 0, 0, 0, 2'($urandom_range(1, 3)));
      else if (r < 17) begin
        issue(3'd3, rk, 8'($urandom) | 8'hCC, 8'h00, 4'd0, 0, 0, 0, 2'($urandom_range(1, 3)));
        drain($urandom_range(0, 2));
      end else if (r == 17)
        issue($urandom_range(0, 1) != 0 ? 3'd0 : 3'd7, rk, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b11);
      else if ($urandom_range(0, 3) == 0)
        issue($urandom_range(0, 1) != 0 ? 3'd5 : 3'd6, 8'h00, 8'h00, 8'h00, 4'd0, 0, 0, 0, 2'b11);
      else
        issue(3'd4, rk, 8'hFF, 8'h00, 4'd0, 0, 0, 0, 2'b11);
    end
    repeat (3) to_pos();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
